// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencer, NZCV flag register and condition check for the multicycle ARM datapath
module multicycle_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         MemReady,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic [1:0]   ResultSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ALUControl,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic         RegWrite,
  output logic         InstrDone
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  state_t state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [1:0] op, dp_alu;
  logic [3:0] cmd, cond;
  logic i_bit, s_bit, rd15, no_write, cond_base, cond_ex;
  logic pcw, irw, mw, rw, done;
  logic unused_rn;
  assign op        = Instr[27:26];
  assign i_bit     = Instr[25];
  assign cmd       = Instr[24:21];
  assign s_bit     = Instr[20];
  assign cond      = Instr[31:28];
  assign rd15      = Instr[15:12] == 4'hf;
  assign unused_rn = ^Instr[19:16];
  assign ImmSrc    = op;
  assign RegSrc    = {op == 2'b01, op == 2'b10};
  assign dp_alu    = (cmd == 4'b0010 || cmd == 4'b1010) ? 2'b01 :
                     (cmd == 4'b0000) ? 2'b10 :
                     (cmd == 4'b1100) ? 2'b11 : 2'b00;
  assign no_write  = cmd == 4'b1010;
  // odd condition codes are the negation of the preceding even code
  always_comb begin
    cond_base = 1'b1;
    case (cond[3:1])
      3'b000:  cond_base = flags_q[2];
      3'b001:  cond_base = flags_q[1];
      3'b010:  cond_base = flags_q[3];
      3'b011:  cond_base = flags_q[0];
      3'b100:  cond_base = flags_q[1] & ~flags_q[2];
      3'b101:  cond_base = flags_q[3] == flags_q[0];
      3'b110:  cond_base = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      default: cond_base = 1'b1;
    endcase
    cond_ex = (cond == 4'hf) ? 1'b0 : cond_base ^ cond[0];
  end
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pcw        = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        irw       = MemReady;
        pcw       = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        done      = ~cond_ex | (op == 2'b11);
        state_d   = done ? FETCH : (op == 2'b01) ? MEMADR : (op == 2'b10) ? BRANCH :
                    i_bit ? EXECUTEI : EXECUTER;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        flags_d[3:2] = s_bit ? ALUFlags[3:2] : flags_q[3:2];
        flags_d[1:0] = (s_bit && !dp_alu[1]) ? ALUFlags[1:0] : flags_q[1:0];
        state_d    = ALUWB;
      end
      ALUWB: begin
        rw      = ~no_write;
        pcw     = ~no_write & rd15;
        done    = 1'b1;
        state_d = FETCH;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Instr[20] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        AdrSrc  = 1'b1;
        mw      = 1'b1;
        done    = MemReady;
        state_d = MemReady ? FETCH : MEMWRITE;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        pcw       = rd15;
        done      = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  // reset suppresses every architectural write in the cycle it is asserted
  assign PCWrite   = pcw & ~reset;
  assign IRWrite   = irw & ~reset;
  assign MemWrite  = mw & ~reset;
  assign RegWrite  = rw & ~reset;
  assign InstrDone = done & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven cycle-by-cycle check of controls plus CPI sequences
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset, MemReady;
  logic [31:12] Instr;
  logic [3:0] ALUFlags;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, InstrDone;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .InstrDone(InstrDone)
  );

  typedef struct {
    string        name;
    logic         rst;
    logic [31:12] instr;
    logic [3:0]   af;
    logic         rdy;
    logic [12:0]  ctl;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite,InstrDone}
  function automatic logic [12:0] c(input logic pcw, input logic adr, input logic mw, input logic irw,
                                    input logic [1:0] rs, input logic sa, input logic [1:0] sb,
                                    input logic [1:0] alu, input logic rw, input logic done);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, rw, done};
  endfunction

  task automatic add(input string n, input logic r, input logic [31:12] i, input logic [3:0] a,
                     input logic m, input logic [12:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.instr = i; v.af = a; v.rdy = m; v.ctl = e;
    vecs.push_back(v);
  endtask

  task automatic cpi(input string n, input logic [31:12] i, input int exp_n);
    int cnt = 0;
    logic seen = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      reset = 1'b0; Instr = i; MemReady = 1'b1; ALUFlags = 4'b0000;
      #1;
      cnt++;
      seen = InstrDone;
    end
    checks++;
    if (!seen || cnt != exp_n) begin
      errors++;
      $display("FAIL cpi_%s: got %0d cycles (done seen=%0b), expected %0d", n, cnt, seen, exp_n);
    end
  endtask

  initial begin
    logic [31:12] adds3, beq, bmi, cmp, eqadd, ldr4, str5, addr15s, addr15, nop, orri, bal;
    logic [12:0] f1, f0, dd, ma, mr, br;
    logic [16:0] got, exp_v;
    adds3   = {4'he, 2'b00, 6'b101001, 4'h0, 4'h3};
    beq     = {4'h0, 2'b10, 6'b000000, 4'h0, 4'h0};
    bmi     = {4'h4, 2'b10, 6'b000000, 4'h0, 4'h0};
    bal     = {4'he, 2'b10, 6'b000000, 4'h0, 4'h0};
    cmp     = {4'he, 2'b00, 6'b110101, 4'h1, 4'h0};
    eqadd   = {4'h0, 2'b00, 6'b001000, 4'h1, 4'h2};
    ldr4    = {4'he, 2'b01, 6'b011001, 4'h1, 4'h4};
    str5    = {4'he, 2'b01, 6'b011000, 4'h1, 4'h5};
    addr15s = {4'he, 2'b00, 6'b001001, 4'h1, 4'hf};
    addr15  = {4'he, 2'b00, 6'b001000, 4'h1, 4'hf};
    nop     = {4'he, 2'b11, 6'b000000, 4'h0, 4'h0};
    orri    = {4'he, 2'b00, 6'b111000, 4'h1, 4'h2};
    f1 = c(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0, 0);
    f0 = c(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 0);
    dd = c(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 1);
    ma = c(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0);
    mr = c(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    br = c(1, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0, 1);
    add("reset_fetch",   1, adds3,   4'b0000, 1, f0);
    add("adds_fetch",    0, adds3,   4'b0000, 1, f1);
    add("adds_decode",   0, adds3,   4'b0000, 1, f0);
    add("adds_execi",    0, adds3,   4'b0110, 1, ma);
    add("adds_aluwb",    0, adds3,   4'b0000, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1));
    add("beq_fetch",     0, beq,     4'b0000, 1, f1);
    add("beq_decode",    0, beq,     4'b0000, 1, f0);
    add("beq_branch",    0, beq,     4'b0000, 1, br);
    add("cmp_fetch",     0, cmp,     4'b0000, 1, f1);
    add("cmp_decode",    0, cmp,     4'b0000, 1, f0);
    add("cmp_execi",     0, cmp,     4'b1000, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0, 0));
    add("cmp_aluwb",     0, cmp,     4'b0000, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    add("eqfail_fetch",  0, eqadd,   4'b0000, 1, f1);
    add("eqfail_decode", 0, eqadd,   4'b0000, 1, dd);
    add("ldr_fetch",     0, ldr4,    4'b0000, 1, f1);
    add("ldr_decode",    0, ldr4,    4'b0000, 1, f0);
    add("ldr_memadr",    0, ldr4,    4'b0000, 1, ma);
    add("ldr_memrd0",    0, ldr4,    4'b0000, 0, mr);
    add("ldr_memrd1",    0, ldr4,    4'b0000, 0, mr);
    add("ldr_memrd2",    0, ldr4,    4'b0000, 1, mr);
    add("ldr_memwb",     0, ldr4,    4'b0000, 1, c(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 1));
    add("str_fetch_stl", 0, str5,    4'b0000, 0, f0);
    add("str_fetch",     0, str5,    4'b0000, 1, f1);
    add("str_decode",    0, str5,    4'b0000, 1, f0);
    add("str_memadr",    0, str5,    4'b0000, 1, ma);
    add("str_memwr",     0, str5,    4'b0000, 1, c(0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    add("rst_fetch",     0, addr15s, 4'b0000, 1, f1);
    add("rst_decode",    0, addr15s, 4'b0000, 1, f0);
    add("rst_in_execr",  1, addr15s, 4'b1000, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    add("post_rst_fet",  0, bmi,     4'b0000, 1, f1);
    add("bmi_flags_clr", 0, bmi,     4'b0000, 1, dd);
    add("nop_fetch",     0, nop,     4'b0000, 1, f1);
    add("nop_decode",    0, nop,     4'b0000, 1, dd);
    add("pcdp_fetch",    0, addr15,  4'b0000, 1, f1);
    add("pcdp_decode",   0, addr15,  4'b0000, 1, f0);
    add("pcdp_execr",    0, addr15,  4'b0100, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    add("pcdp_aluwb",    0, addr15,  4'b0000, 1, c(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1));
    add("beq_ns_fetch",  0, beq,     4'b0000, 1, f1);
    add("beq_ns_decode", 0, beq,     4'b0000, 1, dd);
    add("orr_fetch",     0, orri,    4'b0000, 1, f1);
    add("orr_decode",    0, orri,    4'b0000, 1, f0);
    add("orr_execi",     0, orri,    4'b0000, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b11, 0, 0));
    add("orr_aluwb",     0, orri,    4'b0000, 1, c(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1));
    reset = 1'b1; MemReady = 1'b1; Instr = nop; ALUFlags = 4'b0000;
    repeat (2) @(posedge clk);
    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst; Instr = vecs[k].instr; ALUFlags = vecs[k].af; MemReady = vecs[k].rdy;
      #1;
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
             RegWrite, InstrDone, ImmSrc, RegSrc};
      exp_v = {vecs[k].ctl, vecs[k].instr[27:26], vecs[k].instr[27:26] == 2'b01,
               vecs[k].instr[27:26] == 2'b10};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", vecs[k].name, got, exp_v);
      end
    end
    cpi("nop", nop, 2);
    cpi("branch", bal, 3);
    cpi("dp", orri, 4);
    cpi("str", str5, 4);
    cpi("ldr", ldr4, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM core. It sequences the shared datapath (one memory port, one ALU, instruction register) through fetch, decode, execute, memory and writeback states. It holds the NZCV flag register and evaluates condition codes. It stalls on a memory-ready handshake. It sits beside the multicycle datapath and drives every mux select and write enable.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- Instr  in  20  IR bits [31:12]; valid from DECODE onward, ignored in FETCH
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  memory completes access this cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  0 = PC address, 1 = ALU-result register address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR
- ResultSrc  out  2  00 ALUOut reg, 01 read-data reg, 10 ALU result (direct)
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 register B, 01 extended immediate, 10 constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Instr[27:26]
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- RegWrite  out  1  register-file write enable
- InstrDone  out  1  one-cycle pulse on the last cycle of every instruction

## Operation
Field names:
- Op = Instr[27:26]
- Funct = Instr[25:20], with I = Funct[5], cmd = Funct[4:1], S = Funct[0], L = Funct[0]
- Rd = Instr[15:12], cond = Instr[31:28]

Condition evaluation:
- CondEx is combinational from cond and the flags register, per ARM condition table (EQ..AL).
- 1111 is treated as never.

State and default outputs:
- Moore state register. Outputs not listed for a state are 0. ImmSrc and RegSrc are always driven from Instr.
- FETCH: AdrSrc=0, IRWrite=MemReady, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10, PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10. This reads PC+8.

DECODE transitions:
- CondEx=0 → FETCH; InstrDone=1.
- Op=11 → FETCH; InstrDone=1 (NOP).
- Op=00, I=1 → EXECUTEI.
- Op=00, I=0 → EXECUTER.
- Op=01 → MEMADR.
- Op=10 → BRANCH.

Execute and memory states:
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd. Next state is ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUControl from cmd. Next state is ALUWB.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite). Any other cmd decodes as ADD.
- Flag update in EXECUTE states when S=1:
  - N,Z always load from ALUFlags.
  - C,V load only for ADD/SUB/CMP.
- ALUWB: ResultSrc=00, RegWrite = ~NoWrite, PCWrite = ~NoWrite & (Rd==15). InstrDone=1. Next state is FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALU ADD. L=1 → MEMREAD; L=0 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stays while MemReady=0; goes to MEMWB when MemReady=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady=1. InstrDone=MemReady. Goes to FETCH when MemReady=1.
- MEMWB: ResultSrc=01, RegWrite=1, PCWrite=(Rd==15). InstrDone=1. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALU ADD, ResultSrc=10, PCWrite=1. InstrDone=1. Next state is FETCH.

Reset:
- On the reset clock edge: state ← FETCH, flags ← 0000.
- While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0.
- Reset asserted mid-instruction aborts it. No register, memory or PC write occurs during or after that edge.

## Timing
Cycles per instruction with MemReady held at 1:
- Condition-failed or NOP: 2.
- Branch: 3.
- Data-processing and STR: 4.
- LDR: 5.

Stalls:
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Outputs hold steady during a stall, except the MemReady-qualified enables.

Flag timing:
- Flags change only at the end of an EXECUTE cycle.
- An instruction's CondEx sees the flags produced by all earlier instructions.

## Test plan
- Reset mid-EXECUTER with reset=1 for one cycle → next cycle state FETCH, flags 0000; no RegWrite/PCWrite pulse in the reset cycle.
- ADDS (Instr cond=1110, Op=00, I=1, cmd=0100, S=1, Rd=3) with ALUFlags=0110, MemReady=1:
  - Response: FETCH→DECODE→EXECUTEI→ALUWB, RegWrite=1 in cycle 4, flags=0110.
  - Follow-up: BEQ then takes BRANCH with PCWrite=1.
- CMP (cmd=1010, S=1) → ALUControl=01 in EXECUTE; no RegWrite in ALUWB; InstrDone pulses.
- LDR with MemReady low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles; total 7 cycles; RegWrite=1 only in MEMWB.
- STR with MemReady=0 for 1 cycle in FETCH → IRWrite/PCWrite only on the ready cycle; MemWrite held 1 for exactly 1 cycle in MEMWRITE.
- Condition-fail: flags Z=0 and cond=0000 (EQ) → DECODE→FETCH; zero writes; InstrDone=1 in DECODE.
